// File: rtl/complex_gate.sv
// Parameterized AND-OR / AND-OR-INVERT complex gate with an optional output register stage.
// Define COMPLEX_GATE_REG_EN to build the registered outputs; otherwise they alias the combinational ones.
module complex_gate #(
  parameter int WIDTH = 3,
  parameter int LANES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [LANES*WIDTH-1:0] in,
  output logic [LANES-1:0]       out_ao,
  output logic [LANES-1:0]       out_aoi,
  output logic [LANES-1:0]       out_ao_q,
  output logic [LANES-1:0]       out_aoi_q
);

  // Lane k: AND of every bit below the MSB, ORed with the MSB.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [WIDTH-1:0] lane;
    assign lane      = in[k*WIDTH +: WIDTH];
    assign out_ao[k] = (&lane[WIDTH-2:0]) | lane[WIDTH-1];
  end

  assign out_aoi = ~out_ao;

`ifdef COMPLEX_GATE_REG_EN
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_ao_q  <= '0;
      out_aoi_q <= '1;
    end else if (en) begin
      out_ao_q  <= out_ao;
      out_aoi_q <= out_aoi;
    end
  end
`else
  assign out_ao_q  = out_ao;
  assign out_aoi_q = out_aoi;

  // Control pins stay on the port list for a uniform footprint across builds.
  logic unused_ctrl;
  assign unused_ctrl = &{1'b0, clk, rst_n, en};
`endif

endmodule

// File: tb/tb_complex_gate.sv
// Self-checking bench for complex_gate: a WIDTH=3/LANES=1 instance and a WIDTH=4/LANES=2 instance.
// Register-stage scenarios run only when COMPLEX_GATE_REG_EN is defined.
module tb_complex_gate;

  logic       clk = 1'b0;
  logic       clk_run;
  logic       rst_n;
  logic       en;

  logic [2:0] in3;
  logic [0:0] ao3, aoi3, aoq3, aoiq3;
  logic [7:0] in8;
  logic [1:0] ao8, aoi8, aoq8, aoiq8;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] ao;
    logic [1:0] aoi;
  } exp_t;

  exp_t sb[$];

  complex_gate #(.WIDTH(3), .LANES(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in3),
    .out_ao(ao3), .out_aoi(aoi3), .out_ao_q(aoq3), .out_aoi_q(aoiq3)
  );

  complex_gate #(.WIDTH(4), .LANES(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in8),
    .out_ao(ao8), .out_aoi(aoi8), .out_ao_q(aoq8), .out_aoi_q(aoiq8)
  );

  always #5 if (clk_run) clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    #2;
    checks++;
    if (aoq3 !== 1'b0 || aoiq3 !== 1'b1) begin
      errors++;
      $display("FAIL reset_q3: ao_q=%b aoi_q=%b required 0 1", aoq3, aoiq3);
    end
    checks++;
    if (aoq8 !== 2'b00 || aoiq8 !== 2'b11) begin
      errors++;
      $display("FAIL reset_q8: ao_q=%b aoi_q=%b required 00 11", aoq8, aoiq8);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] ao_tab;
    exp_t e;
    ao_tab = 8'b1111_1000;
    for (int i = 0; i < 8; i++) begin
      in3 = 3'(i);
      sb.push_back('{ao: {1'b0, ao_tab[i]}, aoi: {1'b0, ~ao_tab[i]}});
      #5;
      e = sb.pop_front();
      checks++;
      if (ao3 !== e.ao[0]) begin
        errors++;
        $display("FAIL sweep_ao in=%b: got %b required %b", in3, ao3, e.ao[0]);
      end
      checks++;
      if (aoi3 !== e.aoi[0]) begin
        errors++;
        $display("FAIL sweep_aoi in=%b: got %b required %b", in3, aoi3, e.aoi[0]);
      end
      checks++;
      if ((ao3 ^ aoi3) !== 1'b1) begin
        errors++;
        $display("FAIL sweep_complement in=%b: ao^aoi=%b required 1", in3, ao3 ^ aoi3);
      end
      #5;
    end
  endtask

  task automatic test_lanes();
    logic [7:0] pat [4];
    logic [1:0] req [4];
    exp_t e;
    pat[0] = 8'b0011_1000; req[0] = 2'b01;
    pat[1] = 8'b1000_0111; req[1] = 2'b11;
    pat[2] = 8'b0111_0000; req[2] = 2'b10;
    pat[3] = 8'b0000_0000; req[3] = 2'b00;
    for (int i = 0; i < 4; i++) begin
      in8 = pat[i];
      sb.push_back('{ao: req[i], aoi: ~req[i]});
      #5;
      e = sb.pop_front();
      checks++;
      if (ao8 !== e.ao || aoi8 !== e.aoi) begin
        errors++;
        $display("FAIL lanes in=%b: ao=%b aoi=%b required %b %b", in8, ao8, aoi8, e.ao, e.aoi);
      end
      #5;
    end
  endtask

`ifdef COMPLEX_GATE_REG_EN
  task automatic test_register();
    exp_t e;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    en  = 1'b1;
    in3 = 3'b011;
    sb.push_back('{ao: 2'b01, aoi: 2'b00});
    #1;
    checks++;
    if (aoq3 !== 1'b0 || aoiq3 !== 1'b1) begin
      errors++;
      $display("FAIL reg_before_edge: ao_q=%b aoi_q=%b required 0 1", aoq3, aoiq3);
    end
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (aoq3 !== e.ao[0] || aoiq3 !== e.aoi[0]) begin
      errors++;
      $display("FAIL reg_one_edge: ao_q=%b aoi_q=%b required %b %b", aoq3, aoiq3, e.ao[0], e.aoi[0]);
    end
  endtask

  task automatic test_enable_hold();
    en  = 1'b1;
    in3 = 3'b100;
    @(negedge clk);
    checks++;
    if (aoq3 !== 1'b1 || aoiq3 !== 1'b0) begin
      errors++;
      $display("FAIL hold_load: ao_q=%b aoi_q=%b required 1 0", aoq3, aoiq3);
    end
    en  = 1'b0;
    in3 = 3'b000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (aoq3 !== 1'b1 || aoiq3 !== 1'b0 || ao3 !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: ao_q=%b aoi_q=%b ao=%b required 1 0 0", c, aoq3, aoiq3, ao3);
      end
    end
  endtask

  task automatic test_async_reset();
    en  = 1'b1;
    in3 = 3'b111;
    in8 = 8'b1000_1000;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (aoq3 !== 1'b0 || aoiq3 !== 1'b1 || aoq8 !== 2'b00 || aoiq8 !== 2'b11) begin
      errors++;
      $display("FAIL async_reset: q3=%b/%b q8=%b/%b required 0/1 00/11", aoq3, aoiq3, aoq8, aoiq8);
    end
    checks++;
    if (ao3 !== 1'b1 || ao8 !== 2'b11) begin
      errors++;
      $display("FAIL reset_comb: ao3=%b ao8=%b required 1 11", ao3, ao8);
    end
    // Reset must beat enable on the following edge too.
    @(negedge clk);
    checks++;
    if (aoq3 !== 1'b0 || aoiq3 !== 1'b1) begin
      errors++;
      $display("FAIL reset_priority: ao_q=%b aoi_q=%b required 0 1", aoq3, aoiq3);
    end
    en = 1'b0;
  endtask
`endif

  task automatic test_passthrough();
    exp_t e;
    logic exp_ao;
    clk_run = 1'b0;
    rst_n   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in3 = 3'(i);
      exp_ao = (in3[0] & in3[1]) | in3[2];
`ifdef COMPLEX_GATE_REG_EN
      sb.push_back('{ao: 2'b00, aoi: 2'b01});
`else
      sb.push_back('{ao: {1'b0, exp_ao}, aoi: {1'b0, ~exp_ao}});
`endif
      #1;
      e = sb.pop_front();
      checks++;
      if (aoq3 !== e.ao[0] || aoiq3 !== e.aoi[0]) begin
        errors++;
        $display("FAIL passthrough in=%b: ao_q=%b aoi_q=%b required %b %b",
                 in3, aoq3, aoiq3, e.ao[0], e.aoi[0]);
      end
      #9;
    end
  endtask

  initial begin
    clk_run = 1'b1;
    rst_n   = 1'b0;
    en      = 1'b0;
    in3     = '0;
    in8     = '0;
    test_reset();
    test_sweep();
    test_lanes();
`ifdef COMPLEX_GATE_REG_EN
    test_register();
    test_enable_hold();
    test_async_reset();
`endif
    test_passthrough();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
